// File: rtl/data_mem_stage.sv
// data_mem_stage
//   Multi-cycle data-memory stage behind the ALU. One 64-bit load or store per
//   Start/Ready/Done transaction, with a fixed LATENCY of BUSY cycles.
//   The memory array holds 2**ADDR_WIDTH words. It is word-addressed using
//   Address[ADDR_WIDTH+2:3]. Address bits above that are ignored, so accesses
//   wrap.
//
// Ports
//   CLK        clock, rising edge
//   Reset_n    asynchronous active-low reset (memory contents are not reset)
//   Address    byte address (ALU BusW)
//   WriteData  store data (register-file port B)
//   MemRead    load qualifier
//   MemWrite   store qualifier (wins when both qualifiers are set)
//   Start      transaction request, honoured only while Ready=1
//   Ready      stage idle, can accept Start
//   Done       one-cycle completion pulse
//   ReadData   data of the last completed load; held between loads
//   AlignErr   with Done: access was misaligned and suppressed
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, accesses with Address[2:0] != 0 are
//                        suppressed and flagged on AlignErr. When undefined,
//                        Address[2:0] is ignored and AlignErr is tied low.

module data_mem_stage #(
  parameter int n          = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic [n-1:0] Address,
  input  logic [n-1:0] WriteData,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         Start,
  output logic         Ready,
  output logic         Done,
  output logic [n-1:0] ReadData,
  output logic         AlignErr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            count;
  logic [ADDR_WIDTH-1:0] capWord;
  logic [n-1:0]          capData;
  logic                  capRead;
  logic                  capWrite;
  logic                  capMis;

  logic [n-1:0] mem [0:(2**ADDR_WIDTH)-1];

  logic accept;
  logic finish;
  logic doStore;
  logic doLoad;

  // Start is only honoured in IDLE and only with a real request attached.
  assign accept  = (state == IDLE) && Start && (MemRead || MemWrite);
  // Last BUSY cycle: the memory access happens on this edge.
  assign finish  = (state == BUSY) && (count == '0);
  // A request with both qualifiers set is a pure store.
  assign doStore = finish && capWrite && !capMis;
  assign doLoad  = finish && capRead && !capWrite && !capMis;

  // Control FSM, access counter and load result.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      count    <= '0;
      ReadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            count <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (doLoad) begin
        ReadData <= mem[capWord];
      end
    end
  end

  // Request capture. Later input changes cannot affect a transaction in flight.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      capWord  <= '0;
      capData  <= '0;
      capRead  <= 1'b0;
      capWrite <= 1'b0;
    end else if (accept) begin
      capWord  <= Address[ADDR_WIDTH+2:3];
      capData  <= WriteData;
      capRead  <= MemRead;
      capWrite <= MemWrite;
    end
  end

  // The memory has no reset. If reset hits mid-transaction, the FSM is forced
  // out of BUSY asynchronously, so doStore can never fire for that aborted
  // store.
  always_ff @(posedge CLK) begin
    if (doStore) begin
      mem[capWord] <= capData;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic alignErrQ;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      capMis <= 1'b0;
    end else if (accept) begin
      capMis <= |Address[2:0];
    end
  end

  // Set only on the BUSY->RESP edge, so it is high exactly while Done is high.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      alignErrQ <= 1'b0;
    end else begin
      alignErrQ <= finish && capMis;
    end
  end

  assign AlignErr = alignErrQ;

  logic unusedAddrBits;
  assign unusedAddrBits = ^Address[n-1:ADDR_WIDTH+3];
`else
  assign capMis   = 1'b0;
  assign AlignErr = 1'b0;

  logic unusedAddrBits;
  assign unusedAddrBits = ^{Address[n-1:ADDR_WIDTH+3], Address[2:0]};
`endif

  // Pure decodes of the state register; no input reaches these outputs.
  assign Ready = (state == IDLE);
  assign Done  = (state == RESP);

endmodule
